// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory_bank block: FSM state encoding,
// byte-lane merge and read-latency legality.
package memory_pkg;

  typedef enum logic {
    StInit,
    StReady
  } state_e;

  localparam int unsigned MinReadLatency = 1;
  localparam int unsigned MaxReadLatency = 2;

  function automatic bit read_latency_legal(input int unsigned lat);
    return (lat >= MinReadLatency) && (lat <= MaxReadLatency);
  endfunction

  // One byte lane of the old/wdata merge; the caller applies it to every lane.
  function automatic logic [7:0] merge_lane(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/memory_bank_if.sv
// Access bus of memory_bank: request side driven by the master, qualified
// read data and status returned by the slave.
interface memory_bank_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wr_en;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    init_done;
  logic                    err;

  modport master (
    output addr, wr_en, be, wdata, rd_en,
    input  rdata, rvalid, init_done, err
  );

  modport slave (
    input  addr, wr_en, be, wdata, rd_en,
    output rdata, rvalid, init_done, err
  );

endinterface

// File: rtl/memory_bank_rdpipe.sv
// READ_LATENCY-deep read-data pipeline; data stages only load on valid so the
// output holds its last value between reads.
module memory_bank_rdpipe #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_data  [READ_LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) r_data[0] <= i_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[READ_LATENCY-1];
  assign o_data  = r_data[READ_LATENCY-1];

endmodule

// File: rtl/memory_bank.sv
// Single-port memory bank with byte-lane writes, clocked init sweep after
// reset, selectable read latency and configurable read-during-write.
module memory_bank
  import memory_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 3,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '1,
  parameter int unsigned           READ_LATENCY = 1,
  parameter bit                    WRITE_FIRST  = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  memory_bank_if.slave   bus
);

  localparam int unsigned         Depth    = 2 ** ADDR_WIDTH;
  localparam int unsigned         NumLanes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LastPtr  = (ADDR_WIDTH + 1)'(Depth - 1);
  localparam logic [ADDR_WIDTH:0] PtrOne   = (ADDR_WIDTH + 1)'(1);

  if (!read_latency_legal(READ_LATENCY) || (DATA_WIDTH % 8 != 0)) begin : g_bad_param
    $error("memory_bank: illegal READ_LATENCY or DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH:0]   r_init_ptr, w_init_ptr_next;
  logic                  r_err, w_err_next;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_old, w_merged, w_rd_word;
  logic                  w_rd_accept;
  logic                  w_rvalid;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_old = r_mem[bus.addr];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NumLanes; i++) begin
      w_merged[8*i +: 8] = merge_lane(w_old[8*i +: 8], bus.wdata[8*i +: 8], bus.be[i]);
    end
  end

  // Write-first forwards the merged word so a same-cycle read sees the new lanes.
  assign w_rd_word = (WRITE_FIRST && bus.wr_en) ? w_merged : w_old;

  always_comb begin
    w_state_next    = r_state;
    w_init_ptr_next = r_init_ptr;
    w_err_next      = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_addr      = bus.addr;
    w_mem_wdata     = w_merged;
    w_rd_accept     = 1'b0;
    unique case (r_state)
      StInit: begin
        w_mem_we        = 1'b1;
        w_mem_addr      = r_init_ptr[ADDR_WIDTH-1:0];
        w_mem_wdata     = INIT_VALUE;
        w_init_ptr_next = r_init_ptr + PtrOne;
        w_err_next      = bus.rd_en | bus.wr_en;
        if (r_init_ptr == LastPtr) w_state_next = StReady;
      end
      StReady: begin
        w_mem_we    = bus.wr_en && (|bus.be);
        w_rd_accept = bus.rd_en;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StInit;
      r_init_ptr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_init_ptr <= w_init_ptr_next;
      r_err      <= w_err_next;
    end
  end

  // Array has no reset; the sweep establishes its contents.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  memory_bank_rdpipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (w_rd_accept),
    .i_data  (w_rd_word),
    .o_valid (w_rvalid),
    .o_data  (w_rdata)
  );

  assign bus.rvalid    = w_rvalid;
  assign bus.rdata     = w_rdata;
  assign bus.init_done = (r_state == StReady);
  assign bus.err       = r_err;

endmodule

// File: doc/memory_bank.md
# memory_bank

Parametrised single-port synchronous memory bank. It adds byte-lane write enables, a selectable read latency, and defined read-during-write behaviour. On reset it runs a clocked initialisation sweep that writes INIT_VALUE to every word, so no asynchronous array writes are needed. It is the general-purpose storage block for datapaths that need a known memory state after reset and a qualified read-data stream.

## Interface
Parameters:
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, word width; must be a multiple of 8
- INIT_VALUE, all ones, word value written during the init sweep
- READ_LATENCY, 1, legal values 1 or 2; 2 adds an output register stage
- WRITE_FIRST, 0, same-address read and write in one cycle: 0 = read old data, 1 = read new data

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  ADDR_WIDTH  word address for read and write
- wr_en  in  1  write strobe
- be  in  DATA_WIDTH/8  byte-lane enables for the write; bit i covers wdata[8i+7:8i]
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe
- rdata  out  DATA_WIDTH  read data; valid only while rvalid is high
- rvalid  out  1  one-cycle qualifier for rdata
- init_done  out  1  high once the init sweep is complete
- err  out  1  one-cycle pulse when an access is issued while init_done is low

## Operation
- FSM states:
  - INIT: reset is asserted, or the sweep is running.
  - READY: normal operation.
- While reset is low:
  - state = INIT, init_ptr = 0
  - rdata = 0, rvalid = 0, init_done = 0, err = 0, pipeline registers cleared
  - Array contents are not cleared asynchronously.
- INIT sweep:
  - Each clock writes INIT_VALUE to mem[init_ptr] with all lanes enabled, then increments init_ptr.
  - When init_ptr reaches 2**ADDR_WIDTH-1 and that word is written, the FSM moves to READY and sets init_done.
  - init_ptr is ADDR_WIDTH+1 bits wide, so the sweep terminates without ambiguity.
- Any rd_en or wr_en while in INIT:
  - The access is ignored: no array write and no rvalid.
  - err pulses for exactly one cycle per offending cycle.
- Writes in READY:
  - On wr_en, each byte lane with be[i]=1 is updated; lanes with be[i]=0 keep their value.
  - wr_en with be=0 is a legal no-op and does not raise err.
- Reads in READY:
  - On rd_en, mem[addr] is captured and presented after READ_LATENCY cycles, together with a one-cycle rvalid.
  - Back-to-back reads give back-to-back rvalid.
  - rdata holds its last value while rvalid is low.
- Read and write to the same addr in the same cycle:
  - WRITE_FIRST=0 returns the pre-write word.
  - WRITE_FIRST=1 returns the merged post-write word, with only enabled lanes replaced.
- Read and write to different addresses in the same cycle are independent; addr is shared, so this case cannot occur.
- Reset asserted mid-sweep or mid-read:
  - All state returns to reset values immediately.
  - Pending reads are dropped (no rvalid).
  - The sweep restarts from address 0 after reset is released.

## Timing
- Reset released before rising edge 0 → edges 0 .. 2**ADDR_WIDTH-1 perform the sweep → init_done is high after edge 2**ADDR_WIDTH-1. This is 8 cycles at the default depth.
- The first accepted access is on the first edge that samples init_done=1.
- Read latency: rd_en sampled at edge N → rdata and rvalid valid after edge N+READ_LATENCY-1. With READ_LATENCY=1 they are visible in the cycle after the request.
- Writes take effect at edge N; a read at edge N+1 sees the new data in either mode.
- err rises after the edge that sampled the illegal access and falls after the next edge unless it is re-triggered.

## Structure
- Package memory_pkg holds:
  - the state enum (INIT, READY)
  - a function computing the byte-lane merge of old word, wdata and be
  - the READ_LATENCY legality check constant
- One sub-module, memory_bank_rdpipe: the READ_LATENCY-deep rdata/rvalid pipeline with asynchronous active-low reset.
- The array, FSM and write-merge logic stay in memory_bank.

## Test plan
- Defaults; release reset, wait for init_done (8 cycles); read all 8 addresses → each returns 8'hFF with rvalid one cycle after rd_en; no err.
- Defaults; assert rd_en on cycle 2 of the sweep → err pulses for one cycle, no rvalid, and init_done still rises after edge 7.
- DATA_WIDTH=16; write 16'hA5A5 be=2'b11, then 16'h3C00 be=2'b10 to addr 5; read addr 5 → 16'h3CA5.
- Defaults, WRITE_FIRST=0 then 1; after writing 8'h11 to addr 2, issue wr_en with 8'h22 and rd_en to addr 2 in the same cycle → reads 8'h11 (mode 0) or 8'h22 (mode 1); a following read returns 8'h22 in both.
- READ_LATENCY=2; reads to addr 0,1,2 on consecutive cycles → three consecutive rvalid cycles, starting two cycles after the first request, with data in order.
- Assert reset at sweep cycle 4 after writing addr 3 in a prior session → rdata=0, rvalid=0, init_done=0 immediately; after re-release and the full 8-cycle sweep, addr 3 reads 8'hFF.
